alu_issue_ctrl: RTL and testbench

- Multicycle control FSM for the MIPS datapath; the producer side of the ALU's ALUFun/Sign interface.
- Decodes each fetched instruction into the 6-bit ALUFun and Sign encoding the ALU consumes.
- Holds the ALU controls stable for the ALU's registered latency, then sequences the memory, writeback and PC-update strobes.

---
 rtl/alu_pkg.sv | 69 ++++++
 rtl/alu_issue_ctrl_if.sv | 33 +++
 rtl/alu_issue_decode.sv | 51 +++++
 rtl/alu_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, MIPS encodings and controller types
package alu_pkg;

    localparam logic [1:0] GRP_ADD   = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_CMP   = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1110;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0000;
    localparam logic [3:0] OP_SRL = 4'b0001;
    localparam logic [3:0] OP_SRA = 4'b0011;
    // compare ops always carry the subtract bit in [0]
    localparam logic [3:0] OP_EQ  = 4'b0011;
    localparam logic [3:0] OP_NEQ = 4'b0001;
    localparam logic [3:0] OP_LT  = 4'b0101;

    localparam logic [1:0] SRC_RT    = 2'd0;
    localparam logic [1:0] SRC_SIMM  = 2'd1;
    localparam logic [1:0] SRC_ZIMM  = 2'd2;
    localparam logic [1:0] SRC_SHAMT = 2'd3;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, PCUPD} state_t;
    typedef enum logic [1:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH} iclass_t;

    typedef struct packed {
        logic [5:0] fun;
        logic       sign;
        logic [1:0] src_b;
        logic       reg_dst;
        iclass_t    iclass;
        logic       illegal;
    } dec_t;

    function automatic logic [5:0] mk_fun(input logic [1:0] grp, input logic [3:0] op);
        return {grp, op};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - fetch/memory inputs and ALU/datapath controls of the issue controller
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_flag;
    logic [5:0]  ALUFun;
    logic        Sign;
    logic [1:0]  alu_src_b;
    logic        ir_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        pc_write;
    logic        pc_branch;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        illegal;
    logic        bus_err;
    logic        busy;

    modport master (
        input  instr_valid, instr, mem_ready, alu_flag,
        output ALUFun, Sign, alu_src_b, ir_write, reg_write, mem_read, mem_write,
               pc_write, pc_branch, reg_dst, mem_to_reg, illegal, bus_err, busy
    );

    modport slave (
        output instr_valid, instr, mem_ready, alu_flag,
        input  ALUFun, Sign, alu_src_b, ir_write, reg_write, mem_read, mem_write,
               pc_write, pc_branch, reg_dst, mem_to_reg, illegal, bus_err, busy
    );
endinterface

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational opcode/funct to ALU control decode
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec.fun     = mk_fun(GRP_ADD, OP_ADD);
        dec.sign    = 1'b0;
        dec.src_b   = SRC_RT;
        dec.reg_dst = 1'b0;
        dec.iclass  = C_ALU;
        dec.illegal = 1'b0;
        if (opcode == OPC_RTYPE) begin
            dec.reg_dst = 1'b1;
            case (funct)
                FN_ADD:  dec.sign = 1'b1;
                FN_ADDU: dec.sign = 1'b0;
                FN_SUB:  begin dec.fun = mk_fun(GRP_ADD, OP_SUB); dec.sign = 1'b1; end
                FN_SUBU: dec.fun = mk_fun(GRP_ADD, OP_SUB);
                FN_AND:  dec.fun = mk_fun(GRP_LOGIC, OP_AND);
                FN_OR:   dec.fun = mk_fun(GRP_LOGIC, OP_OR);
                FN_XOR:  dec.fun = mk_fun(GRP_LOGIC, OP_XOR);
                FN_NOR:  dec.fun = mk_fun(GRP_LOGIC, OP_NOR);
                FN_SLT:  begin dec.fun = mk_fun(GRP_CMP, OP_LT); dec.sign = 1'b1; end
                FN_SLTU: dec.fun = mk_fun(GRP_CMP, OP_LT);
                FN_SLL:  begin dec.fun = mk_fun(GRP_SHIFT, OP_SLL); dec.src_b = SRC_SHAMT; end
                FN_SRL:  begin dec.fun = mk_fun(GRP_SHIFT, OP_SRL); dec.src_b = SRC_SHAMT; end
                FN_SRA:  begin dec.fun = mk_fun(GRP_SHIFT, OP_SRA); dec.src_b = SRC_SHAMT; end
                default: dec.illegal = 1'b1;
            endcase
        end else begin
            case (opcode)
                OPC_ADDI:  begin dec.sign = 1'b1; dec.src_b = SRC_SIMM; end
                OPC_ADDIU: dec.src_b = SRC_SIMM;
                OPC_ANDI:  begin dec.fun = mk_fun(GRP_LOGIC, OP_AND); dec.src_b = SRC_ZIMM; end
                OPC_ORI:   begin dec.fun = mk_fun(GRP_LOGIC, OP_OR); dec.src_b = SRC_ZIMM; end
                OPC_SLTI:  begin dec.fun = mk_fun(GRP_CMP, OP_LT); dec.sign = 1'b1; dec.src_b = SRC_SIMM; end
                OPC_LW:    begin dec.sign = 1'b1; dec.src_b = SRC_SIMM; dec.iclass = C_LOAD; end
                OPC_SW:    begin dec.sign = 1'b1; dec.src_b = SRC_SIMM; dec.iclass = C_STORE; end
                OPC_BEQ:   begin dec.fun = mk_fun(GRP_CMP, OP_EQ); dec.sign = 1'b1; dec.iclass = C_BRANCH; end
                OPC_BNE:   begin dec.fun = mk_fun(GRP_CMP, OP_NEQ); dec.sign = 1'b1; dec.iclass = C_BRANCH; end
                default:   dec.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multicycle issue FSM driving ALUFun/Sign and datapath strobes
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input logic              clk,
    input logic              reset,
    alu_issue_ctrl_if.master bus
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    iclass_t       iclass;
    logic [5:0]    ir_op;
    logic [5:0]    ir_fn;
    logic [2:0]    exec_cnt;
    logic [TW-1:0] mem_cnt;
    dec_t          dec;
    logic          unused_instr_bits;

    // only opcode and funct steer control; register fields belong to the datapath
    assign unused_instr_bits = ^bus.instr[25:6];

    alu_issue_decode u_decode (
        .opcode (ir_op),
        .funct  (ir_fn),
        .dec    (dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= FETCH;
            iclass         <= C_ALU;
            ir_op          <= '0;
            ir_fn          <= '0;
            exec_cnt       <= '0;
            mem_cnt        <= '0;
            bus.ALUFun     <= '0;
            bus.Sign       <= 1'b0;
            bus.alu_src_b  <= '0;
            bus.reg_dst    <= 1'b0;
            bus.ir_write   <= 1'b0;
            bus.reg_write  <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.pc_write   <= 1'b0;
            bus.pc_branch  <= 1'b0;
            bus.mem_to_reg <= 1'b0;
            bus.illegal    <= 1'b0;
            bus.bus_err    <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.ir_write   <= 1'b0;
            bus.reg_write  <= 1'b0;
            bus.pc_write   <= 1'b0;
            bus.pc_branch  <= 1'b0;
            bus.mem_to_reg <= 1'b0;
            bus.illegal    <= 1'b0;
            bus.bus_err    <= 1'b0;
            case (state)
                FETCH: if (bus.instr_valid) begin
                    ir_op        <= bus.instr[31:26];
                    ir_fn        <= bus.instr[5:0];
                    bus.ir_write <= 1'b1;
                    bus.busy     <= 1'b1;
                    state        <= DECODE;
                end
                DECODE: if (dec.illegal) begin
                    bus.illegal <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= FETCH;
                end else begin
                    bus.ALUFun    <= dec.fun;
                    bus.Sign      <= dec.sign;
                    bus.alu_src_b <= dec.src_b;
                    bus.reg_dst   <= dec.reg_dst;
                    iclass        <= dec.iclass;
                    exec_cnt      <= 3'(ALU_LAT - 1);
                    state         <= EXEC;
                end
                EXEC: if (exec_cnt == '0) begin
                    mem_cnt <= '0;
                    case (iclass)
                        C_LOAD:   begin bus.mem_read <= 1'b1; state <= MEM; end
                        C_STORE:  begin bus.mem_write <= 1'b1; state <= MEM; end
                        // alu_flag on the last EXEC cycle is the branch outcome
                        C_BRANCH: begin bus.pc_write <= 1'b1; bus.pc_branch <= bus.alu_flag; state <= PCUPD; end
                        default:  begin bus.reg_write <= 1'b1; state <= WB; end
                    endcase
                end else begin
                    exec_cnt <= exec_cnt - 1'b1;
                end
                MEM: if (bus.mem_ready) begin
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                    if (iclass == C_LOAD) begin
                        bus.reg_write  <= 1'b1;
                        bus.mem_to_reg <= 1'b1;
                        state          <= WB;
                    end else begin
                        bus.pc_write <= 1'b1;
                        state        <= PCUPD;
                    end
                end else if (mem_cnt == TW'(MEM_TIMEOUT - 1)) begin
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                    bus.bus_err   <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= FETCH;
                end else begin
                    mem_cnt <= mem_cnt + 1'b1;
                end
                WB: begin
                    bus.pc_write <= 1'b1;
                    state        <= PCUPD;
                end
                PCUPD: begin
                    bus.busy <= 1'b0;
                    state    <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with randomized instruction stream
module tb_alu_issue_ctrl;

    localparam int LAT = 3;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.ALU_LAT(LAT), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // cls: 0 alu, 1 load, 2 store, 3 branch, 4 unsupported
    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] fun;
        logic       sign;
        logic [1:0] srcb;
        int         cls;
    } ins_t;

    // kind: 0 retires with pc_write, 1 illegal, 2 bus_err
    typedef struct {
        string      nm;
        int         kind;
        logic [5:0] fun;
        logic       sign;
        logic [1:0] srcb;
        logic       regdst;
        int         busy_n;
        int         rw_n;
        logic       mtr;
        int         mr_n;
        int         mw_n;
        logic       pb;
    } exp_t;

    ins_t tab[$];
    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic [5:0] fun, input logic sign, input logic [1:0] srcb, input int cls);
        ins_t t;
        t.nm = nm; t.op = op; t.fn = fn; t.fun = fun; t.sign = sign; t.srcb = srcb; t.cls = cls;
        tab.push_back(t);
    endtask

    function automatic int find(input string nm);
        foreach (tab[i]) if (tab[i].nm == nm) return i;
        return 0;
    endfunction

    function automatic logic [31:0] mkword(input ins_t t);
        logic [31:0] r;
        r = $urandom;
        if (t.op == 6'd0) return {6'd0, r[19:0], t.fn};
        return {t.op, r[25:0]};
    endfunction

    // d = cycle of MEM on which mem_ready arrives, 0 = never
    function automatic exp_t model(input ins_t t, input int d, input bit taken);
        exp_t e;
        int   m;
        m = (d == 0) ? TMO : d;
        e.nm = t.nm; e.kind = 0; e.fun = t.fun; e.sign = t.sign; e.srcb = t.srcb;
        e.regdst = (t.op == 6'd0);
        e.rw_n = 0; e.mtr = 1'b0; e.mr_n = 0; e.mw_n = 0; e.pb = 1'b0;
        case (t.cls)
            0: begin e.busy_n = 1 + LAT + 2; e.rw_n = 1; end
            3: begin e.busy_n = 1 + LAT + 1; e.pb = taken; end
            1, 2: begin
                if (t.cls == 1) e.mr_n = m; else e.mw_n = m;
                if (d == 0) begin e.kind = 2; e.busy_n = 1 + LAT + m; end
                else if (t.cls == 1) begin e.busy_n = 1 + LAT + m + 2; e.rw_n = 1; e.mtr = 1'b1; end
                else e.busy_n = 1 + LAT + m + 1;
            end
            default: begin e.kind = 1; e.busy_n = 1; end
        endcase
        return e;
    endfunction

    task automatic issue(input ins_t t, input logic [31:0] word, input int d, input bit taken);
        exp_t e;
        int   m;
        int   w;
        bit   in_mem;
        e = model(t, d, taken);
        m = (d == 0) ? TMO : d;
        sbq.push_back(e);
        bus.instr_valid = 1'b1;
        bus.instr = word;
        bus.alu_flag = 1'($urandom);
        bus.mem_ready = 1'($urandom);
        @(negedge clk);
        for (int k = 0; k < e.busy_n; k++) begin
            bus.instr_valid = 1'($urandom);
            bus.instr = $urandom;
            bus.alu_flag = (k == LAT) ? taken : 1'($urandom);
            in_mem = (t.cls == 1 || t.cls == 2) && k > LAT && k <= LAT + m;
            bus.mem_ready = in_mem ? (d != 0 && k == LAT + d) : 1'($urandom);
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        bus.mem_ready = 1'b0;
        w = 0;
        while (bus.busy && w < 64) begin @(negedge clk); w++; end
        if (bus.busy) begin
            n_chk++; n_fail++;
            $display("FAIL %s.fetch_return: busy still 1 after 64 extra cycles, expected 0", t.nm);
        end
    endtask

    bit         open = 0;
    int         k_cyc, o_busy, o_rw, o_mr, o_mw;
    logic       o_mtr, o_pb, o_unstable;
    logic [9:0] snap;

    function automatic logic [9:0] ctl_now();
        return {bus.ALUFun, bus.Sign, bus.alu_src_b, bus.reg_dst};
    endfunction

    task automatic close_rec(input int kind);
        exp_t e;
        n_chk++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got completion kind %0d, expected none", kind);
            return;
        end
        e = sbq.pop_front();
        check({e.nm, ".kind"}, kind, e.kind);
        check({e.nm, ".busy_cycles"}, o_busy, e.busy_n);
        if (e.kind != 1) begin
            check({e.nm, ".ALUFun"}, snap[9:4], e.fun);
            check({e.nm, ".Sign"}, snap[3], e.sign);
            check({e.nm, ".alu_src_b"}, snap[2:1], e.srcb);
            check({e.nm, ".reg_dst"}, snap[0], e.regdst);
            check({e.nm, ".ctl_changed"}, o_unstable, 0);
        end
        check({e.nm, ".reg_write_cycles"}, o_rw, e.rw_n);
        check({e.nm, ".mem_to_reg"}, o_mtr, e.mtr);
        check({e.nm, ".mem_read_cycles"}, o_mr, e.mr_n);
        check({e.nm, ".mem_write_cycles"}, o_mw, e.mw_n);
        check({e.nm, ".pc_branch"}, o_pb, e.pb);
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            open = 0;
        end else if (bus.ir_write) begin
            n_chk++;
            if (open) begin
                n_fail++;
                $display("FAIL overlap: ir_write got 1 with an instruction in flight, expected 0");
            end
            open = 1; k_cyc = 0; o_busy = bus.busy ? 1 : 0;
            o_rw = 0; o_mr = 0; o_mw = 0; o_mtr = 1'b0; o_pb = 1'b0; o_unstable = 1'b0; snap = '0;
        end else if (open) begin
            k_cyc++;
            if (bus.busy) o_busy++;
            if (bus.reg_write) begin o_rw++; if (bus.mem_to_reg) o_mtr = 1'b1; end
            if (bus.mem_read) o_mr++;
            if (bus.mem_write) o_mw++;
            if (k_cyc == 1) snap = ctl_now();
            else if (bus.busy && ctl_now() != snap) o_unstable = 1'b1;
            if (bus.pc_write) o_pb = bus.pc_branch;
            if (bus.illegal || bus.bus_err || bus.pc_write) begin
                close_rec(bus.illegal ? 1 : (bus.bus_err ? 2 : 0));
                open = 0;
            end
        end else begin
            check("idle_strobes", {bus.reg_write, bus.mem_read, bus.mem_write, bus.pc_write,
                                   bus.pc_branch, bus.mem_to_reg, bus.illegal, bus.bus_err}, 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.mem_ready = 1'b0;
        bus.alu_flag = 1'b0;

        add("add",  6'h00, 6'h20, 6'b000000, 1, 0, 0); add("addu", 6'h00, 6'h21, 6'b000000, 0, 0, 0);
        add("sub",  6'h00, 6'h22, 6'b000001, 1, 0, 0); add("subu", 6'h00, 6'h23, 6'b000001, 0, 0, 0);
        add("and",  6'h00, 6'h24, 6'b011000, 0, 0, 0); add("or",   6'h00, 6'h25, 6'b011110, 0, 0, 0);
        add("xor",  6'h00, 6'h26, 6'b010110, 0, 0, 0); add("nor",  6'h00, 6'h27, 6'b010001, 0, 0, 0);
        add("slt",  6'h00, 6'h2a, 6'b110101, 1, 0, 0); add("sltu", 6'h00, 6'h2b, 6'b110101, 0, 0, 0);
        add("sll",  6'h00, 6'h00, 6'b100000, 0, 3, 0); add("srl",  6'h00, 6'h02, 6'b100001, 0, 3, 0);
        add("sra",  6'h00, 6'h03, 6'b100011, 0, 3, 0);
        add("addi", 6'h08, 6'h00, 6'b000000, 1, 1, 0); add("addiu", 6'h09, 6'h00, 6'b000000, 0, 1, 0);
        add("andi", 6'h0c, 6'h00, 6'b011000, 0, 2, 0); add("ori",  6'h0d, 6'h00, 6'b011110, 0, 2, 0);
        add("slti", 6'h0a, 6'h00, 6'b110101, 1, 1, 0);
        add("lw",   6'h23, 6'h00, 6'b000000, 1, 1, 1); add("sw",   6'h2b, 6'h00, 6'b000000, 1, 1, 2);
        add("beq",  6'h04, 6'h00, 6'b110011, 1, 0, 3); add("bne",  6'h05, 6'h00, 6'b110001, 1, 0, 3);
        add("bad_fn3f", 6'h00, 6'h3f, 6'b000000, 0, 0, 4); add("bad_fn01", 6'h00, 6'h01, 6'b000000, 0, 0, 4);
        add("bad_j",    6'h02, 6'h00, 6'b000000, 0, 0, 4); add("bad_op3f", 6'h3f, 6'h00, 6'b000000, 0, 0, 4);

        repeat (2) @(negedge clk);
        check("reset.strobes", {bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write, bus.pc_write,
                                bus.pc_branch, bus.mem_to_reg, bus.illegal, bus.bus_err}, 0);
        check("reset.ALUFun", bus.ALUFun, 0);
        check("reset.Sign", bus.Sign, 0);
        check("reset.alu_src_b", bus.alu_src_b, 0);
        check("reset.busy", bus.busy, 0);
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1;

        issue(tab[find("add")], 32'h0022_1820, 0, 0);
        issue(tab[find("beq")], mkword(tab[find("beq")]), 0, 1);
        issue(tab[find("beq")], mkword(tab[find("beq")]), 0, 0);
        issue(tab[find("lw")], mkword(tab[find("lw")]), 4, 0);
        issue(tab[find("lw")], mkword(tab[find("lw")]), 1, 0);
        issue(tab[find("sw")], mkword(tab[find("sw")]), 0, 0);
        issue(tab[find("bad_fn3f")], mkword(tab[find("bad_fn3f")]), 0, 0);
        issue(tab[find("sra")], mkword(tab[find("sra")]), 0, 0);

        for (int n = 0; n < 70; n++) begin
            idx = $urandom_range(0, tab.size() - 1);
            issue(tab[idx], mkword(tab[idx]), $urandom_range(0, 6), 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                bus.alu_flag = 1'($urandom);
                bus.mem_ready = 1'($urandom);
                @(negedge clk);
            end
            bus.mem_ready = 1'b0;
        end
        @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        mon_en = 0;

        bus.instr_valid = 1'b1;
        bus.instr = 32'h0022_1822;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset.ALUFun", bus.ALUFun, 6'b000001);
        check("pre_reset.busy", bus.busy, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset.strobes", {bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write, bus.pc_write,
                                    bus.pc_branch, bus.mem_to_reg, bus.illegal, bus.bus_err}, 0);
        check("mid_reset.ALUFun", bus.ALUFun, 0);
        check("mid_reset.Sign", bus.Sign, 0);
        check("mid_reset.busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset.busy", bus.busy, 0);
        check("post_reset.strobes", {bus.reg_write, bus.pc_write, bus.mem_read, bus.mem_write}, 0);
        mon_en = 1;
        issue(tab[find("add")], 32'h0022_1820, 0, 0);
        @(negedge clk);
        check("scoreboard_final", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
